limber_gnrl_idiv: RTL and testbench

LIMBER_GNRL_IDIV -- requirements
Module: limber_gnrl_idiv

---
 rtl/limber_gnrl_pkg.sv | 21 ++
 rtl/limber_gnrl_idiv_step.sv | 36 +++
 rtl/limber_gnrl_idiv.sv | 248 ++++++++++++++++++++++++
 tb/tb_limber_gnrl_idiv.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/limber_gnrl_pkg.sv
// -----------------------------------------------------------------------------
// limber_gnrl_pkg
// Shared definitions for the limber_gnrl integer divider:
//   - state_e   : 2-bit FSM state encoding (IDLE, CALC, FIX, DONE)
//   - cnt_width : width of an iteration counter able to hold 0..dw
// -----------------------------------------------------------------------------
package limber_gnrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Counter width needed to count dw iterations
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 32'sd1);
    endfunction

endpackage

// File: rtl/limber_gnrl_idiv_step.sv
// -----------------------------------------------------------------------------
// limber_gnrl_idiv_step
// One combinational restoring-division step.
// Ports:
//   prem    [DW2:0]   : partial remainder with the next dividend bit shifted in
//   dsr     [DW2-1:0] : divisor magnitude
//   rem_nxt [DW2-1:0] : partial remainder after the trial subtraction
//   q_bit             : quotient bit produced by this step
// -----------------------------------------------------------------------------
module limber_gnrl_idiv_step #(
    parameter int DW2 = 32
) (
    input  logic [DW2:0]   prem,
    input  logic [DW2-1:0] dsr,
    output logic [DW2-1:0] rem_nxt,
    output logic           q_bit
);

    logic           ge_s;
    logic [DW2-1:0] diff_s;

    // Trial subtraction; keep the difference only when it does not borrow
    always_comb begin
        ge_s   = (prem >= {1'b0, dsr});
        // When ge_s holds, the difference is below dsr and fits in DW2 bits
        diff_s = prem[DW2-1:0] - dsr;
        if (ge_s) begin
            rem_nxt = diff_s;
            q_bit   = 1'b1;
        end else begin
            rem_nxt = prem[DW2-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/limber_gnrl_idiv.sv
// -----------------------------------------------------------------------------
// limber_gnrl_idiv
// Iterative restoring integer divider (signed or unsigned), one quotient bit
// per cycle, valid/ready handshake on both sides. Quotient truncates toward
// zero; the remainder takes the sign of the dividend.
// Ports:
//   i_clk, i_rst_n (async, active low), i_clr (synchronous abort)
//   i_valid / o_ready            : request handshake
//   i_signed, i_dividend[DW1], i_divisor[DW2] : request operands
//   o_valid / i_ready            : result handshake
//   o_quo[DW1], o_rem[DW2], o_dbz, o_ovf : result and flags (qualified by o_valid)
// Optional feature: define LIMBER_GNRL_IDIV_FASTPATH_EN to answer divide-by-zero
// and signed-overflow requests without running the iterations.
// -----------------------------------------------------------------------------
module limber_gnrl_idiv
    import limber_gnrl_pkg::*;
#(
    parameter int DW1 = 32,
    parameter int DW2 = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_signed,
    input  logic [DW1-1:0] i_dividend,
    input  logic [DW2-1:0] i_divisor,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [DW1-1:0] o_quo,
    output logic [DW2-1:0] o_rem,
    output logic           o_dbz,
    output logic           o_ovf
);

    localparam int             CW       = cnt_width(DW1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW1 - 1);
    localparam logic [DW1-1:0] DVD_MIN  = {1'b1, {(DW1-1){1'b0}}};
    localparam logic [DW1-1:0] QUO_ONES = {DW1{1'b1}};
    localparam logic [DW2-1:0] REM_ZERO = {DW2{1'b0}};

    state_e         state_r, state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [DW1-1:0] quo_r;
    logic [DW2-1:0] prem_r, dsr_r, dvd_lo_r;
    logic           signed_r, sgn_dvd_r, sgn_dsr_r, dbz_r, ovf_r;
    logic           o_ready_r, o_valid_r, o_dbz_r, o_ovf_r;
    logic [DW1-1:0] o_quo_r;
    logic [DW2-1:0] o_rem_r;

    logic           in_dvd_neg_s, in_dsr_neg_s, in_dbz_s, in_ovf_s;
    logic [DW1-1:0] in_dvd_mag_s;
    logic [DW2-1:0] in_dsr_mag_s;
    logic [DW2-1:0] step_rem_s;
    logic           step_q_s;
    logic [DW1-1:0] fix_quo_s;
    logic [DW2-1:0] fix_rem_s;

    assign o_ready = o_ready_r;
    assign o_valid = o_valid_r;
    assign o_quo   = o_quo_r;
    assign o_rem   = o_rem_r;
    assign o_dbz   = o_dbz_r;
    assign o_ovf   = o_ovf_r;

    // Operand decode: magnitudes (signed mode only) and special-case detection
    always_comb begin
        in_dvd_neg_s = i_signed & i_dividend[DW1-1];
        in_dsr_neg_s = i_signed & i_divisor[DW2-1];
        in_dvd_mag_s = in_dvd_neg_s ? -i_dividend : i_dividend;
        in_dsr_mag_s = in_dsr_neg_s ? -i_divisor  : i_divisor;
        in_dbz_s     = (i_divisor == {DW2{1'b0}});
        in_ovf_s     = i_signed & (i_dividend == DVD_MIN) & (&i_divisor);
    end

    limber_gnrl_idiv_step #(.DW2(DW2)) u_step (
        .prem    ({prem_r, quo_r[DW1-1]}),
        .dsr     (dsr_r),
        .rem_nxt (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Sign correction of the magnitude result, with special-case overrides
    always_comb begin
        fix_quo_s = quo_r;
        fix_rem_s = prem_r;
        if (dbz_r) begin
            fix_quo_s = QUO_ONES;
            fix_rem_s = dvd_lo_r;
        end else if (ovf_r) begin
            fix_quo_s = DVD_MIN;
            fix_rem_s = REM_ZERO;
        end else begin
            if (signed_r && (sgn_dvd_r ^ sgn_dsr_r)) begin
                fix_quo_s = -quo_r;
            end else begin
                fix_quo_s = quo_r;
            end
            if (signed_r && sgn_dvd_r) begin
                fix_rem_s = -prem_r;
            end else begin
                fix_rem_s = prem_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; abort wins over acceptance and consumption
    always_comb begin
        state_nxt_s = state_r;
        if (i_clr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
`ifdef LIMBER_GNRL_IDIV_FASTPATH_EN
                        if (in_dbz_s || in_ovf_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_CALC;
                        end
`else
                        state_nxt_s = ST_CALC;
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_FIX: begin
                    state_nxt_s = ST_DONE;
                end
                ST_DONE: begin
                    if (o_valid_r && i_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Iteration counter; returns to zero when CALC ends or on abort
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (i_clr) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == ST_CALC) begin
            cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : (cnt_r + CNT_ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand capture on acceptance, one restoring step per CALC cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_r     <= {DW1{1'b0}};
            prem_r    <= REM_ZERO;
            dsr_r     <= REM_ZERO;
            dvd_lo_r  <= REM_ZERO;
            signed_r  <= 1'b0;
            sgn_dvd_r <= 1'b0;
            sgn_dsr_r <= 1'b0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (!i_clr && (state_r == ST_IDLE) && i_valid) begin
            // The dividend magnitude is shifted out MSB-first while quotient bits enter
            quo_r     <= in_dvd_mag_s;
            prem_r    <= REM_ZERO;
            dsr_r     <= in_dsr_mag_s;
            dvd_lo_r  <= i_dividend[DW2-1:0];
            signed_r  <= i_signed;
            sgn_dvd_r <= i_dividend[DW1-1];
            sgn_dsr_r <= i_divisor[DW2-1];
            dbz_r     <= in_dbz_s;
            ovf_r     <= in_ovf_s;
        end else if (state_r == ST_CALC) begin
            quo_r  <= {quo_r[DW1-2:0], step_q_s};
            prem_r <= step_rem_s;
        end else begin
            quo_r  <= quo_r;
            prem_r <= prem_r;
        end
    end

    // Handshake outputs; o_valid rises one cycle after entering DONE from IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
        end else begin
            o_ready_r <= (state_nxt_s == ST_IDLE);
            o_valid_r <= (state_nxt_s == ST_DONE) && (state_r != ST_IDLE);
        end
    end

    // Result registers, loaded once per operation and held through DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_quo_r <= {DW1{1'b0}};
            o_rem_r <= REM_ZERO;
            o_dbz_r <= 1'b0;
            o_ovf_r <= 1'b0;
        end else if ((state_r == ST_FIX) && (state_nxt_s == ST_DONE)) begin
            o_quo_r <= fix_quo_s;
            o_rem_r <= fix_rem_s;
            o_dbz_r <= dbz_r;
            o_ovf_r <= ovf_r;
`ifdef LIMBER_GNRL_IDIV_FASTPATH_EN
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_DONE)) begin
            o_quo_r <= in_ovf_s ? DVD_MIN  : QUO_ONES;
            o_rem_r <= in_ovf_s ? REM_ZERO : i_dividend[DW2-1:0];
            o_dbz_r <= in_dbz_s;
            o_ovf_r <= in_ovf_s;
`endif
        end else begin
            o_quo_r <= o_quo_r;
            o_rem_r <= o_rem_r;
            o_dbz_r <= o_dbz_r;
            o_ovf_r <= o_ovf_r;
        end
    end

endmodule

// File: tb/tb_limber_gnrl_idiv.sv
// -----------------------------------------------------------------------------
// tb_limber_gnrl_idiv
// Directed self-checking bench for limber_gnrl_idiv with DW1 = DW2 = 8.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, i.e. the value the next rising edge will see. Latency k means o_valid
// is first seen high by the k-th rising edge after the accepting edge.
// -----------------------------------------------------------------------------
module tb_limber_gnrl_idiv;

`ifdef LIMBER_GNRL_IDIV_FASTPATH_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 10;
`endif
    localparam int LAT_NORMAL = 10;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_clr, i_valid, i_signed, i_ready;
    logic [7:0] i_dividend, i_divisor;
    logic       o_ready, o_valid, o_dbz, o_ovf;
    logic [7:0] o_quo, o_rem;

    int errors = 0;
    int checks = 0;

    limber_gnrl_idiv #(.DW1(8), .DW2(8)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quo      (o_quo),
        .o_rem      (o_rem),
        .o_dbz      (o_dbz),
        .o_ovf      (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return at the falling edge after the accepting edge
    task automatic start_op(input string tag, input logic sg, input logic [7:0] dvd,
                            input logic [7:0] dsr);
        chk({tag, "_ready_before"}, {63'd0, o_ready}, 64'd1);
        i_valid    = 1'b1;
        i_signed   = sg;
        i_dividend = dvd;
        i_divisor  = dsr;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_signed   = ~sg;
        i_dividend = ~dvd;
        i_divisor  = dsr + 8'd3;
        chk({tag, "_busy"}, {63'd0, o_ready}, 64'd0);
    endtask

    // Wait (bounded) for o_valid and check latency, results and flags
    task automatic wait_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input logic eovf, input int elat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (o_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge i_clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_quo"}, {56'd0, o_quo}, {56'd0, eq});
        chk({tag, "_rem"}, {56'd0, o_rem}, {56'd0, er});
        chk({tag, "_dbz"}, {63'd0, o_dbz}, {63'd0, edbz});
        chk({tag, "_ovf"}, {63'd0, o_ovf}, {63'd0, eovf});
    endtask

    // Consume the result and check the return to IDLE
    task automatic finish_op(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        chk({tag, "_valid_after"}, {63'd0, o_valid}, 64'd0);
        chk({tag, "_ready_after"}, {63'd0, o_ready}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [7:0] dvd,
                          input logic [7:0] dsr, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf, input int elat);
        start_op(tag, sg, dvd, dsr);
        wait_result(tag, eq, er, edbz, eovf, elat);
        finish_op(tag);
    endtask

    // Watch a number of cycles and count any o_valid
    task automatic watch_quiet(input string tag, input int ncyc);
        int seen;
        seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                seen++;
            end
        end
        chk({tag, "_no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_clr      = 1'b0;
        i_valid    = 1'b0;
        i_signed   = 1'b0;
        i_ready    = 1'b0;
        i_dividend = 8'h00;
        i_divisor  = 8'h00;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_quo",   {56'd0, o_quo},   64'd0);
        chk("rst_rem",   {56'd0, o_rem},   64'd0);
        chk("rst_dbz",   {63'd0, o_dbz},   64'd0);
        chk("rst_ovf",   {63'd0, o_ovf},   64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Main function
        run_op("u100_7",   1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, LAT_NORMAL);
        run_op("s_m7_2",   1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, LAT_NORMAL);
        run_op("u249_2",   1'b0, 8'hF9,  8'h02, 8'h7C, 8'h01, 1'b0, 1'b0, LAT_NORMAL);
        run_op("s_7_m2",   1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, LAT_NORMAL);
        run_op("s_min_1",  1'b1, 8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0, LAT_NORMAL);
        run_op("u255_255", 1'b0, 8'hFF,  8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, LAT_NORMAL);
        run_op("u3_7",     1'b0, 8'h03,  8'h07, 8'h00, 8'h03, 1'b0, 1'b0, LAT_NORMAL);

        // Special cases
        run_op("s_ovf",    1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, LAT_SPECIAL);
        run_op("u_dbz",    1'b0, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, LAT_SPECIAL);
        run_op("s_dbz",    1'b1, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, LAT_SPECIAL);
        run_op("s_dbz_neg",1'b1, 8'hF0,  8'h00, 8'hFF, 8'hF0, 1'b1, 1'b0, LAT_SPECIAL);

        // Back-pressure: hold results for 5 cycles while a new request is offered
        start_op("hold", 1'b0, 8'h2A, 8'h05);
        wait_result("hold", 8'h08, 8'h02, 1'b0, 1'b0, LAT_NORMAL);
        i_valid    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 8'h09;
        i_divisor  = 8'h03;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("hold_valid", {63'd0, o_valid}, 64'd1);
            chk("hold_quo",   {56'd0, o_quo},   64'h08);
            chk("hold_rem",   {56'd0, o_rem},   64'h02);
            chk("hold_ready", {63'd0, o_ready}, 64'd0);
        end
        // Consume with i_valid still high: no acceptance on the consuming edge
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("cons_valid", {63'd0, o_valid}, 64'd0);
        chk("cons_ready", {63'd0, o_ready}, 64'd1);
        // The still-pending request is accepted on the next edge
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_dividend = 8'hEE;
        i_divisor  = 8'h01;
        chk("next_busy", {63'd0, o_ready}, 64'd0);
        wait_result("u9_3", 8'h03, 8'h00, 1'b0, 1'b0, LAT_NORMAL);
        finish_op("u9_3");

        // Abort in CALC cycle 4
        start_op("clr", 1'b0, 8'd100, 8'd7);
        repeat (3) @(negedge i_clk);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        chk("clr_ready", {63'd0, o_ready}, 64'd1);
        chk("clr_valid", {63'd0, o_valid}, 64'd0);
        watch_quiet("clr", 15);

        // Reset in CALC cycle 3
        start_op("rst", 1'b1, 8'hF9, 8'h02);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, o_ready}, 64'd1);
        chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("mid_rst_quo",   {56'd0, o_quo},   64'd0);
        chk("mid_rst_rem",   {56'd0, o_rem},   64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        watch_quiet("rst", 15);

        run_op("u200_13", 1'b0, 8'd200, 8'd13, 8'h0F, 8'h05, 1'b0, 1'b0, LAT_NORMAL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
